// File: rtl/sram_ctrl.sv
// sram_ctrl: single-word read/write sequencer for a 16-bit asynchronous SRAM.
// Each access walks SETUP -> STROBE -> (LATCH, reads only) -> RECOVER -> IDLE.
// Every SRAM pin comes straight from a flop, so req_* never reaches sram_*
// combinationally. done is also registered and is high for the RECOVER cycle.
module sram_ctrl #(
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              done,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              sram_ce_n,
    output logic              sram_ce2,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_lb_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    // The counter counts down from (length-1) to 0. It is shared by STROBE and LATCH.
    localparam int MAX_CNT = (WAIT_CYCLES > READ_LAT) ? WAIT_CYCLES : READ_LAT;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LOAD  = CNT_W'(READ_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        LATCH,
        RECOVER
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_wr_q, is_wr_d;
    logic              ce_n_q, ce_n_d;
    logic              ce2_q, ce2_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              lb_n_q, lb_n_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              accept;

    // Requests are accepted only in IDLE. They are also refused while reset is held.
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Next-state and next-pin logic. The pin values are chosen for the state being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        ce_n_d  = ce_n_q;
        ce2_d   = ce2_q;
        we_n_d  = we_n_q;
        oe_n_d  = oe_n_q;
        lb_n_d  = lb_n_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Latch the request once; later changes on req_* are ignored.
                    state_d = SETUP;
                    is_wr_d = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    ce_n_d  = 1'b0;
                    ce2_d   = 1'b1;
                    lb_n_d  = 1'b0;
                end
            end

            SETUP: begin
                // Address was stable for one cycle. Drop exactly one strobe now.
                state_d = STROBE;
                cnt_d   = STROBE_LOAD;
                if (is_wr_q) begin
                    we_n_d = 1'b0;
                end else begin
                    oe_n_d = 1'b0;
                end
            end

            STROBE: begin
                if (cnt_q == '0) begin
                    we_n_d = 1'b1;
                    oe_n_d = 1'b1;
                    if (is_wr_q) begin
                        state_d = RECOVER;
                        ce_n_d  = 1'b1;
                        ce2_d   = 1'b0;
                        lb_n_d  = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LATCH;
                        cnt_d   = LATCH_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            LATCH: begin
                // Chip stays enabled while the read data settles. Capture it on the last edge.
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    rdata_d = sram_rdata;
                    ce_n_d  = 1'b1;
                    ce2_d   = 1'b0;
                    lb_n_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            RECOVER: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                ce_n_d  = 1'b1;
                ce2_d   = 1'b0;
                we_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                lb_n_d  = 1'b1;
            end
        endcase
    end

    // State and pin registers. Reset drops any in-flight access immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            ce_n_q  <= 1'b1;
            ce2_q   <= 1'b0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            ce_n_q  <= ce_n_d;
            ce2_q   <= ce2_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            lb_n_q  <= lb_n_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign done       = done_q;
    assign resp_rdata = rdata_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_ce2   = ce2_q;
    assign sram_we_n  = we_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_lb_n  = lb_n_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl. Two instances are used: dut0 has WAIT_CYCLES=1 and READ_LAT=1.
// dut1 has WAIT_CYCLES=3 and READ_LAT=2. Each instance drives a simple SRAM model.
// Expected values come from the access rules: latency is 2+W(+L), the strobe is low
// for W cycles, and read data is the last value written to that address.
module tb_sram_ctrl;
    localparam int AW = 22;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst, req_valid, req_ready, req_we, done;
    logic [1:0] ce_n, ce2, we_n, oe_n, lb_n;
    logic [AW-1:0] req_addr [2];
    logic [AW-1:0] sram_addr [2];
    logic [DW-1:0] req_wdata [2];
    logic [DW-1:0] resp_rdata [2];
    logic [DW-1:0] sram_wdata [2];
    logic [DW-1:0] sram_rdata [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: one word store per instance, plus the last read result.
    logic [DW-1:0] ref_mem [logic [AW:0]];
    logic [DW-1:0] ref_rd [2];

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1), .READ_LAT(1)) dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .done(done[0]), .resp_rdata(resp_rdata[0]), .sram_ce_n(ce_n[0]), .sram_ce2(ce2[0]),
        .sram_we_n(we_n[0]), .sram_oe_n(oe_n[0]), .sram_lb_n(lb_n[0]),
        .sram_addr(sram_addr[0]), .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0]));

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3), .READ_LAT(2)) dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .done(done[1]), .resp_rdata(resp_rdata[1]), .sram_ce_n(ce_n[1]), .sram_ce2(ce2[1]),
        .sram_we_n(we_n[1]), .sram_oe_n(oe_n[1]), .sram_lb_n(lb_n[1]),
        .sram_addr(sram_addr[1]), .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1]));

    function automatic int wc(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int lc(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    // SRAM model and protocol monitor, one per instance.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic [DW-1:0] mem [0:(1<<AW)-1];
        logic [DW-1:0] rd_q = '0;
        logic          prev_done = 1'b0;
        assign sram_rdata[g] = rd_q;

        always @(posedge clk) begin
            if (ce_n[g] === 1'b0 && ce2[g] === 1'b1) begin
                if (we_n[g] === 1'b0) mem[sram_addr[g]] <= sram_wdata[g];
                if (oe_n[g] === 1'b0) rd_q <= mem[sram_addr[g]];
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                checks++;
                if (we_n[g] === 1'b0 && oe_n[g] === 1'b0) begin
                    errors++;
                    $display("FAIL proto_both_strobes dut%0d: we_n=%b oe_n=%b, required not both 0", g, we_n[g], oe_n[g]);
                end
                checks++;
                if ((we_n[g] !== 1'b1 || oe_n[g] !== 1'b1) && !(ce_n[g] === 1'b0 && ce2[g] === 1'b1)) begin
                    errors++;
                    $display("FAIL proto_strobe_ce dut%0d: ce_n=%b ce2=%b while strobe low, required 0/1", g, ce_n[g], ce2[g]);
                end
                checks++;
                if (prev_done && done[g] === 1'b1) begin
                    errors++;
                    $display("FAIL proto_done_pulse dut%0d: done high 2 cycles, required 1", g);
                end
            end
            prev_done <= (done[g] === 1'b1);
        end
    end

    // Issue one access and trace the pins until done. The reference model is updated here.
    // hold=1 keeps req_valid high and changes req_addr/req_wdata on every busy cycle.
    task automatic do_op(input int d, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] v,
                         input bit hold, output int lat, output int we_lo, output int oe_lo,
                         output int ce_lo, output bit pins_ok, output bit busy_ok);
        int n;
        bit got;
        logic [AW:0] key;
        lat = -1; we_lo = 0; oe_lo = 0; ce_lo = 0; pins_ok = 1'b1; busy_ok = 1'b1;
        key = {d[0], a};
        n = 0;
        @(negedge clk);
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready[d] !== 1'b1) return;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = v;
        @(posedge clk);
        #1;
        if (!hold) req_valid[d] = 1'b0;
        req_addr[d]  = AW'($urandom);
        req_wdata[d] = DW'($urandom);
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (we_n[d] === 1'b0) we_lo++;
            if (oe_n[d] === 1'b0) oe_lo++;
            if (ce_n[d] === 1'b0) ce_lo++;
            if (ce_n[d] === 1'b0 && sram_addr[d] !== a) pins_ok = 1'b0;
            if (ce_n[d] === 1'b0 && we && sram_wdata[d] !== v) pins_ok = 1'b0;
            if (hold) begin
                if (req_ready[d] !== 1'b0) busy_ok = 1'b0;
                req_addr[d]  = AW'($urandom);
                req_wdata[d] = DW'($urandom);
            end
            if (done[d] === 1'b1) begin
                got = 1'b1;
                lat = k;
            end
        end
        if (we) ref_mem[key] = v;
        else    ref_rd[d] = ref_mem.exists(key) ? ref_mem[key] : '0;
    endtask

    task automatic test_reset();
        rst = 2'b11; req_valid = 2'b00; req_we = 2'b00;
        for (int d = 0; d < 2; d++) begin
            req_addr[d] = '0;
            req_wdata[d] = '0;
            ref_rd[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({ce_n[d], ce2[d], we_n[d], oe_n[d], lb_n[d], done[d]} !== 6'b101110) begin
                errors++;
                $display("FAIL reset_pins dut%0d: got %b, required 101110", d, {ce_n[d], ce2[d], we_n[d], oe_n[d], lb_n[d], done[d]});
            end
            checks++;
            if (sram_addr[d] !== '0 || sram_wdata[d] !== '0 || resp_rdata[d] !== '0) begin
                errors++;
                $display("FAIL reset_data dut%0d: addr=%h wdata=%h rdata=%h, required 0", d, sram_addr[d], sram_wdata[d], resp_rdata[d]);
            end
            checks++;
            if (req_ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready_in_rst dut%0d: got %b, required 0", d, req_ready[d]);
            end
        end
        rst = 2'b00;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready_after dut%0d: got %b, required 1", d, req_ready[d]);
            end
        end
        chk_en = 1'b1;
    endtask

    task automatic test_basic();
        int lat, wl, ol, cl;
        bit pok, bok;
        do_op(0, 1'b1, 22'h001234, 16'hBEEF, 1'b0, lat, wl, ol, cl, pok, bok);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL basic_wr_latency: got %0d, required 3", lat); end
        checks++;
        if (wl != 1 || ol != 0) begin errors++; $display("FAIL basic_wr_strobe: we_low=%0d oe_low=%0d, required 1/0", wl, ol); end
        checks++;
        if (resp_rdata[0] !== ref_rd[0]) begin errors++; $display("FAIL basic_rdata_hold: got %h, required %h", resp_rdata[0], ref_rd[0]); end
        do_op(0, 1'b0, 22'h001234, 16'h0000, 1'b0, lat, wl, ol, cl, pok, bok);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL basic_rd_latency: got %0d, required 4", lat); end
        checks++;
        if (resp_rdata[0] !== ref_rd[0]) begin errors++; $display("FAIL basic_rd_data: got %h, required %h", resp_rdata[0], ref_rd[0]); end
        checks++;
        if (ol != 1 || wl != 0 || cl != 3) begin errors++; $display("FAIL basic_rd_pins: oe_low=%0d we_low=%0d ce_low=%0d, required 1/0/3", ol, wl, cl); end
    endtask

    task automatic test_addr_extremes();
        int lat, wl, ol, cl;
        bit pok, bok;
        logic [AW-1:0] addrs [4];
        logic [DW-1:0] datas [4];
        bit            wes [4];
        addrs = '{22'h3FFFFF, 22'h000000, 22'h3FFFFF, 22'h000000};
        datas = '{16'hA5A5, 16'h5A5A, 16'h0000, 16'h0000};
        wes   = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            do_op(0, wes[i], addrs[i], datas[i], 1'b0, lat, wl, ol, cl, pok, bok);
            checks++;
            if (!pok) begin errors++; $display("FAIL extreme_pins[%0d]: sram_addr/wdata deviated, required %h", i, addrs[i]); end
            checks++;
            if (resp_rdata[0] !== ref_rd[0]) begin errors++; $display("FAIL extreme_rdata[%0d]: got %h, required %h", i, resp_rdata[0], ref_rd[0]); end
        end
    endtask

    task automatic test_long_timing();
        int lat, wl, ol, cl;
        bit pok, bok;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        a = AW'($urandom);
        v = DW'($urandom);
        do_op(1, 1'b1, a, v, 1'b0, lat, wl, ol, cl, pok, bok);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL long_wr_latency: got %0d, required 5", lat); end
        checks++;
        if (wl != 3 || cl != 4) begin errors++; $display("FAIL long_wr_pins: we_low=%0d ce_low=%0d, required 3/4", wl, cl); end
        do_op(1, 1'b0, a, 16'h0000, 1'b0, lat, wl, ol, cl, pok, bok);
        checks++;
        if (lat != 7) begin errors++; $display("FAIL long_rd_latency: got %0d, required 7", lat); end
        checks++;
        if (ol != 3 || cl != 6) begin errors++; $display("FAIL long_rd_pins: oe_low=%0d ce_low=%0d, required 3/6", ol, cl); end
        checks++;
        if (resp_rdata[1] !== ref_rd[1]) begin errors++; $display("FAIL long_rd_data: got %h, required %h", resp_rdata[1], ref_rd[1]); end
    endtask

    task automatic test_busy_hold();
        int lat, wl, ol, cl;
        bit pok, bok, got;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        a = AW'($urandom);
        v = DW'($urandom);
        do_op(0, 1'b1, a, v, 1'b1, lat, wl, ol, cl, pok, bok);
        checks++;
        if (!bok) begin errors++; $display("FAIL busy_ready: req_ready=1 while busy, required 0"); end
        checks++;
        if (!pok || lat != 3) begin errors++; $display("FAIL busy_latched: pins_ok=%0d latency=%0d, required 1/3", pok, lat); end
        // req_valid is still high. Switch to a read of the same word. It must be taken on the first IDLE cycle.
        req_we[0] = 1'b0;
        req_addr[0] = a;
        @(negedge clk);
        checks++;
        if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL busy_idle_ready: got %b, required 1", req_ready[0]); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        checks++;
        if (ce_n[0] !== 1'b0 || sram_addr[0] !== a) begin
            errors++;
            $display("FAIL busy_next_accept: ce_n=%b addr=%h, required 0/%h", ce_n[0], sram_addr[0], a);
        end
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (done[0] === 1'b1) got = 1'b1;
        end
        ref_rd[0] = v;
        checks++;
        if (!got || resp_rdata[0] !== ref_rd[0]) begin
            errors++;
            $display("FAIL busy_read_back: done=%0d rdata=%h, required 1/%h", got, resp_rdata[0], ref_rd[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        int lat, wl, ol, cl;
        bit pok, bok, seen;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0] = 1'b0;
        req_addr[0] = 22'h001234;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (oe_n[0] !== 1'b0) begin errors++; $display("FAIL rstmid_in_strobe: oe_n=%b, required 0", oe_n[0]); end
        rst[0] = 1'b1;
        @(negedge clk);
        checks++;
        if ({ce_n[0], ce2[0], we_n[0], oe_n[0], lb_n[0], done[0]} !== 6'b101110 || sram_addr[0] !== '0) begin
            errors++;
            $display("FAIL rstmid_pins: got %b addr=%h, required 101110/0", {ce_n[0], ce2[0], we_n[0], oe_n[0], lb_n[0], done[0]}, sram_addr[0]);
        end
        checks++;
        if (resp_rdata[0] !== 16'h0000) begin errors++; $display("FAIL rstmid_rdata: got %h, required 0000", resp_rdata[0]); end
        rst[0] = 1'b0;
        ref_rd[0] = '0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done[0] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rstmid_no_done: done pulsed, required none"); end
        do_op(0, 1'b0, 22'h001234, 16'h0000, 1'b0, lat, wl, ol, cl, pok, bok);
        checks++;
        if (lat != 4 || resp_rdata[0] !== ref_rd[0]) begin
            errors++;
            $display("FAIL rstmid_recover: latency=%0d rdata=%h, required 4/%h", lat, resp_rdata[0], ref_rd[0]);
        end
    endtask

    task automatic test_random_traffic();
        int lat, wl, ol, cl, exp_lat;
        bit pok, bok, we;
        logic [AW-1:0] pool [2][6];
        logic [AW-1:0] a;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 6; i++) begin
                pool[d][i] = AW'($urandom);
                do_op(d, 1'b1, pool[d][i], DW'($urandom), 1'b0, lat, wl, ol, cl, pok, bok);
            end
        end
        for (int i = 0; i < 40; i++) begin
            int d;
            d = i % 2;
            we = $urandom_range(0, 1) != 0;
            a = pool[d][$urandom_range(0, 5)];
            do_op(d, we, a, DW'($urandom), 1'b0, lat, wl, ol, cl, pok, bok);
            exp_lat = 2 + wc(d) + (we ? 0 : lc(d));
            checks++;
            if (lat != exp_lat) begin errors++; $display("FAIL rand_latency[%0d] dut%0d: got %0d, required %0d", i, d, lat, exp_lat); end
            checks++;
            if ((we ? wl : ol) != wc(d) || !pok) begin
                errors++;
                $display("FAIL rand_strobe[%0d] dut%0d: strobe_low=%0d pins_ok=%0d, required %0d/1", i, d, we ? wl : ol, pok, wc(d));
            end
            checks++;
            if (resp_rdata[d] !== ref_rd[d]) begin errors++; $display("FAIL rand_rdata[%0d] dut%0d: got %h, required %h", i, d, resp_rdata[d], ref_rd[d]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_addr_extremes();
        test_long_timing();
        test_busy_hold();
        test_reset_mid_read();
        test_random_traffic();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Initiator-side controller for the on-board 16-bit asynchronous-style SRAM, which uses active-low CE/WE/OE/LB and an active-high CE2.
- Accepts single-word read/write requests from the host bridge over a valid/ready handshake.
- Sequences the SRAM control pins through setup, strobe, read-latch and recovery phases, then returns read data and a completion pulse.
- Sits between the MCU bus bridge and the SRAM pins, or the SRAM behavioural model in simulation.

Parameters:
- ADDR_W, 22, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 1, cycles WE_n/OE_n is held low per access. Must be ≥1.
- READ_LAT, 1, cycles from the last strobe edge to capture of sram_rdata. Must be ≥1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  host request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- done  out  1  one-cycle completion pulse, for reads and writes.
- resp_rdata  out  DATA_W  last read data; valid when done is high after a read.
- sram_ce_n  out  1  chip enable, active low.
- sram_ce2  out  1  chip enable 2, active high.
- sram_we_n  out  1  write strobe, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_lb_n  out  1  lower-byte enable, active low.
- sram_addr  out  ADDR_W  address to SRAM.
- sram_wdata  out  DATA_W  write data to SRAM.
- sram_rdata  in  DATA_W  read data from SRAM.

Behaviour:
- Reset values: state IDLE; sram_ce_n=1, sram_ce2=0, sram_we_n=1, sram_oe_n=1, sram_lb_n=1; sram_addr=0, sram_wdata=0; done=0, resp_rdata=0.
- req_ready = (state==IDLE) && !rst.
- All SRAM outputs are registered; no combinational paths from req_* to sram_*.
- Handshake:
  - Accept on a posedge with req_valid && req_ready.
  - req_we, req_addr and req_wdata are latched only at acceptance; later changes are ignored.
  - req_valid while busy is ignored and not queued.
- FSM states: IDLE, SETUP, STROBE, LATCH, RECOVER.
- IDLE:
  - CE inactive, strobes high.
  - On acceptance, go to SETUP.
- SETUP, 1 cycle:
  - sram_ce_n=0, sram_ce2=1, sram_lb_n=0.
  - Address and write data are valid; we_n=1, oe_n=1.
  - Go to STROBE.
- STROBE, WAIT_CYCLES cycles:
  - Chip enables held.
  - Write: sram_we_n=0, oe_n=1.
  - Read: sram_oe_n=0, we_n=1.
  - Never both low.
  - On count end, write goes to RECOVER and read goes to LATCH.
- LATCH, READ_LAT cycles, reads only:
  - Chip enables held; both strobes high.
  - sram_rdata captured into resp_rdata at the final LATCH edge.
  - Go to RECOVER.
- RECOVER, 1 cycle:
  - sram_ce_n=1, sram_ce2=0, sram_lb_n=1; strobes high.
  - done=1 for exactly this cycle.
  - Go to IDLE.
- resp_rdata holds its value across writes; only reads update it.
- Latency from the accepting edge to the done cycle:
  - write: 2+WAIT_CYCLES cycles;
  - read: 2+WAIT_CYCLES+READ_LAT cycles.
- Minimum request spacing: done cycle + 1 IDLE cycle, then the next acceptance.
- Address and data cover the full range 0 to 2^ADDR_W−1; no wrap logic, since the address passes through unmodified.
- Reset mid-access:
  - On the next edge, return to IDLE with all outputs at their reset values.
  - No done pulse; the in-flight request is dropped.
  - A partially strobed write may or may not have landed; the host must re-issue it.
- Strobe and wait counter: wide enough for max(WAIT_CYCLES, READ_LAT); reloaded on every state entry.

Test Plan:
1. Reset, then write 0x00_1234←0xBEEF, then read 0x00_1234:
   - done 3 cycles after write acceptance;
   - done 4 cycles after read acceptance, with resp_rdata=0xBEEF;
   - sram_we_n low exactly 1 cycle.
2. Address extremes: write 0x3FFFFF←0xA5A5 and 0x000000←0x5A5A, read both back:
   - exact data returned;
   - sram_addr matches on every active cycle.
3. WAIT_CYCLES=3, READ_LAT=2:
   - write done at +5 cycles, read done at +7 cycles;
   - oe_n low 3 cycles; ce_n low from SETUP through LATCH.
4. req_valid held high with changing req_addr during a write:
   - req_ready=0 while busy;
   - latched address unchanged;
   - next request accepted on the first IDLE cycle after done.
5. Assert rst during STROBE of a read:
   - next cycle all SRAM pins at reset values;
   - no done pulse; resp_rdata=0;
   - the next read completes normally.
6. Protocol checker across random traffic:
   - we_n and oe_n never both low;
   - strobes only low while ce_n=0 and ce2=1;
   - done is always a single-cycle pulse.
